// File: rtl/ddr_sdram_copy.sv
// Copies 1 KiB bursts from a DDR burst-read port into a 16-bit toggle-handshake SDRAM writer.
// Optional running checksum output enabled by defining DDR_SDRAM_COPY_CHECKSUM_EN.
module ddr_sdram_copy #(
    parameter int FIFO_DEPTH = 256
) (
    input  logic        DDRAM_CLK,
    input  logic        nRESET,
    input  logic        start,
    input  logic [27:0] src_addr,
    input  logic [24:0] dst_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [27:0] cpaddr,
    output logic        cpreq,
    input  logic        cpbusy,
    input  logic        cpwr,
    input  logic [63:0] cpdout,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic        sd_req,
    input  logic        sd_ack
`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
    ,
    output logic [15:0] csum
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] FREE_MIN = (AW+1)'(128);

    typedef enum logic [2:0] {
        F_IDLE     = 3'd0,
        F_REQ      = 3'd1,
        F_WAITBUSY = 3'd2,
        F_STREAM   = 3'd3,
        F_GAP      = 3'd4
    } fetch_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EMIT = 2'd1,
        W_WAIT = 2'd2
    } wr_t;

    fetch_t fstate_r, fnext_s;
    wr_t    wstate_r, wnext_s;

    logic [17:0]   src_hi_r;
    logic [15:0]   num_r, burst_k_r;
    logic [6:0]    wcnt_r;
    logic [1:0]    low_cnt_r;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_r, rptr_r;
    logic [AW:0]   count_r, free_s;
    logic [63:0]   word_r;
    logic [1:0]    hw_idx_r;
    logic [24:0]   wr_addr_r, hw_left_r;
    logic [15:0]   hw_sel_s;
    logic          busy_r, done_r, ovf_r, cpreq_r, sd_req_r;
    logic [27:0]   cpaddr_r;
    logic [24:0]   sd_addr_r;
    logic [15:0]   sd_din_r;
    logic          start_acc_s, in_stream_s, full_s, empty_s, push_s, drop_s;
    logic          issue_s, grant_s, pop_s, emit_s, acked_s, finish_s;
    logic          unused_s;

    // Only the 1 KiB-aligned part of the source address matters.
    assign unused_s = ^src_addr[9:0];

    assign start_acc_s = start & ~busy_r & (fstate_r == F_IDLE);
    assign in_stream_s = (fstate_r == F_STREAM);
    assign full_s      = (count_r == DEPTH_V);
    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign free_s      = DEPTH_V - count_r;
    assign push_s      = cpwr & in_stream_s & ~full_s;
    assign drop_s      = cpwr & ~(in_stream_s & ~full_s);

    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;
    assign cpreq  = cpreq_r;
    assign cpaddr = cpaddr_r;
    assign sd_req = sd_req_r;
    assign sd_addr = sd_addr_r;
    assign sd_din  = sd_din_r;

    // Fetch FSM next-state: a burst is only requested when a whole burst fits.
    always_comb begin
        fnext_s = fstate_r;
        issue_s = 1'b0;
        grant_s = 1'b0;
        case (fstate_r)
            F_IDLE: begin
                if (start_acc_s && (num_bursts != 16'd0)) fnext_s = F_REQ;
                else fnext_s = F_IDLE;
            end
            F_REQ: begin
                if (free_s >= FREE_MIN) begin
                    issue_s = 1'b1;
                    fnext_s = F_WAITBUSY;
                end else begin
                    fnext_s = F_REQ;
                end
            end
            F_WAITBUSY: begin
                if (cpbusy) begin
                    grant_s = 1'b1;
                    fnext_s = F_STREAM;
                end else begin
                    fnext_s = F_WAITBUSY;
                end
            end
            F_STREAM: begin
                if (cpwr && (wcnt_r == 7'd127)) fnext_s = F_GAP;
                else fnext_s = F_STREAM;
            end
            F_GAP: begin
                if (!cpbusy && (low_cnt_r == 2'd2)) begin
                    if (burst_k_r == num_r) fnext_s = F_IDLE;
                    else fnext_s = F_REQ;
                end else begin
                    fnext_s = F_GAP;
                end
            end
            default: fnext_s = F_IDLE;
        endcase
    end

    // Write engine next-state: one popped word yields four handshaked halfwords.
    always_comb begin
        wnext_s  = wstate_r;
        pop_s    = 1'b0;
        emit_s   = 1'b0;
        acked_s  = 1'b0;
        finish_s = 1'b0;
        case (wstate_r)
            W_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    wnext_s = W_EMIT;
                end else begin
                    wnext_s = W_IDLE;
                end
            end
            W_EMIT: begin
                emit_s  = 1'b1;
                wnext_s = W_WAIT;
            end
            W_WAIT: begin
                if (sd_ack == sd_req_r) begin
                    acked_s = 1'b1;
                    if (hw_left_r == 25'd1) begin
                        finish_s = 1'b1;
                        wnext_s  = W_IDLE;
                    end else if (hw_idx_r == 2'd3) begin
                        wnext_s = W_IDLE;
                    end else begin
                        wnext_s = W_EMIT;
                    end
                end else begin
                    wnext_s = W_WAIT;
                end
            end
            default: wnext_s = W_IDLE;
        endcase
    end

    // Halfword select, least significant first.
    always_comb begin
        hw_sel_s = 16'd0;
        case (hw_idx_r)
            2'd0:    hw_sel_s = word_r[15:0];
            2'd1:    hw_sel_s = word_r[31:16];
            2'd2:    hw_sel_s = word_r[47:32];
            2'd3:    hw_sel_s = word_r[63:48];
            default: hw_sel_s = 16'd0;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            fstate_r <= F_IDLE;
            wstate_r <= W_IDLE;
        end else begin
            fstate_r <= fnext_s;
            wstate_r <= wnext_s;
        end
    end

    // Burst request side: address generation, word count and cpreq low-time tracking.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            src_hi_r  <= 18'd0;
            num_r     <= 16'd0;
            burst_k_r <= 16'd0;
            cpreq_r   <= 1'b0;
            cpaddr_r  <= 28'd0;
            wcnt_r    <= 7'd0;
            low_cnt_r <= 2'd0;
        end else begin
            if (start_acc_s) begin
                src_hi_r  <= src_addr[27:10];
                num_r     <= num_bursts;
                burst_k_r <= 16'd0;
            end
            if (issue_s) begin
                cpreq_r   <= 1'b1;
                cpaddr_r  <= {src_hi_r + {2'b00, burst_k_r}, 10'd0};
                burst_k_r <= burst_k_r + 16'd1;
            end
            if (grant_s) begin
                cpreq_r <= 1'b0;
                wcnt_r  <= 7'd0;
            end else if (cpwr && in_stream_s) begin
                wcnt_r <= wcnt_r + 7'd1;
            end
            if (cpreq_r) low_cnt_r <= 2'd0;
            else if (low_cnt_r != 2'd2) low_cnt_r <= low_cnt_r + 2'd1;
        end
    end

    // FIFO storage carries no reset; emptiness comes from the pointers.
    always_ff @(posedge DDRAM_CLK) begin
        if (push_s) mem[wptr_r] <= cpdout;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rptr_r <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // SDRAM write datapath.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            word_r    <= 64'd0;
            hw_idx_r  <= 2'd0;
            wr_addr_r <= 25'd0;
            hw_left_r <= 25'd0;
            sd_req_r  <= 1'b0;
            sd_addr_r <= 25'd0;
            sd_din_r  <= 16'd0;
        end else begin
            if (start_acc_s) begin
                wr_addr_r <= dst_addr;
                hw_left_r <= {num_bursts, 9'd0};
            end
            if (pop_s) begin
                word_r   <= mem[rptr_r];
                hw_idx_r <= 2'd0;
            end
            if (emit_s) begin
                sd_req_r  <= ~sd_req_r;
                sd_din_r  <= hw_sel_s;
                sd_addr_r <= wr_addr_r;
                wr_addr_r <= wr_addr_r + 25'd1;
            end
            if (acked_s) begin
                hw_left_r <= hw_left_r - 25'd1;
                hw_idx_r  <= hw_idx_r + 2'd1;
            end
        end
    end

    // Copy status: busy/done/ovf; a dropped word wins over the clear on start.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start_acc_s) begin
                busy_r <= (num_bursts != 16'd0);
                done_r <= (num_bursts == 16'd0);
            end else if (finish_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
            if (drop_s) ovf_r <= 1'b1;
            else if (start_acc_s) ovf_r <= 1'b0;
        end
    end

`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
    logic [15:0] csum_r;
    assign csum = csum_r;

    // Running sum of every halfword handed to the SDRAM side.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            csum_r <= 16'd0;
        end else if (start_acc_s) begin
            csum_r <= 16'd0;
        end else if (emit_s) begin
            csum_r <= csum_r + hw_sel_s;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_sdram_copy.sv
// Scoreboard bench for ddr_sdram_copy: burst-source and ack responders plus a write monitor.
module tb_ddr_sdram_copy;

    logic        DDRAM_CLK = 1'b0;
    logic        nRESET, start, cpbusy, cpwr, sd_ack;
    logic [27:0] src_addr, cpaddr;
    logic [24:0] dst_addr, sd_addr;
    logic [15:0] num_bursts, sd_din;
    logic [63:0] cpdout;
    logic        busy, done, ovf, cpreq, sd_req;
`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
    logic [15:0] csum;
`endif

    ddr_sdram_copy #(.FIFO_DEPTH(256)) dut (
        .DDRAM_CLK(DDRAM_CLK), .nRESET(nRESET), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .ovf(ovf),
        .cpaddr(cpaddr), .cpreq(cpreq), .cpbusy(cpbusy), .cpwr(cpwr), .cpdout(cpdout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_req(sd_req), .sd_ack(sd_ack)
`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    initial forever #5 DDRAM_CLK = ~DDRAM_CLK;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [40:0] exp_q[$];
    logic [27:0] exp_addr_q[$];
    int          data_mode = 0;
    int          ack_delay = 0;
    int          hw_pushed = 0;
    int          gw = 0;
    int          toggles = 0;
    int          done_cnt = 0;
    int          cpreq_cnt = 0;
    int          done_save = 0;
    logic [24:0] dst_m = 25'd0;
    logic [15:0] csum_m = 16'd0;
    logic        prev_req = 1'b0;
    int          cps = 0;
    int          widx = 0;
    int          ack_cnt = 0;
    logic [63:0] d;
    logic [40:0] e;
    logic [27:0] ea;
    logic        seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Burst source: answer cpreq with cpbusy, then stream 128 words and record expected writes.
    initial forever begin
        @(negedge DDRAM_CLK);
        if (!nRESET) begin
            cps = 0; cpbusy = 1'b0; cpwr = 1'b0;
        end else begin
            case (cps)
                0: if (cpreq) begin
                    cpreq_cnt++;
                    ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 28'hFFF_FFFF;
                    check_val("cpaddr", cpaddr, ea);
                    cps = 1;
                end
                1: begin cpbusy = 1'b1; cps = 2; end
                2: if (!cpreq) begin widx = 0; cps = 3; end
                3: begin
                    case (data_mode)
                        0: d = 64'(gw);
                        1: d = 64'h0001_0001_0001_0001;
                        default: d = {$urandom, $urandom};
                    endcase
                    gw++;
                    cpwr = 1'b1; cpdout = d;
                    for (int h = 0; h < 4; h++) begin
                        exp_q.push_back({25'(dst_m + 25'(hw_pushed)), d[16*h +: 16]});
                        hw_pushed++;
                    end
                    widx++;
                    if (widx == 128) cps = 4;
                end
                default: begin cpwr = 1'b0; cpbusy = 1'b0; cps = 0; end
            endcase
        end
    end

    // SDRAM acknowledger with a programmable delay.
    initial forever begin
        @(negedge DDRAM_CLK);
        if (!nRESET) begin
            sd_ack = 1'b0; ack_cnt = 0;
        end else if (sd_req != sd_ack) begin
            if (ack_cnt >= ack_delay) begin sd_ack = sd_req; ack_cnt = 0; end
            else ack_cnt++;
        end
    end

    // Write monitor: every sd_req toggle is one halfword checked against the scoreboard.
    initial forever begin
        @(negedge DDRAM_CLK);
        if (!nRESET) begin
            prev_req = 1'b0;
        end else begin
            if (sd_req != prev_req) begin
                prev_req = sd_req;
                toggles++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : {41{1'b1}};
                check_val("sd_write", {sd_addr, sd_din}, e);
                csum_m = csum_m + sd_din;
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_copy(input logic [27:0] s, input logic [24:0] dd, input logic [15:0] n);
        @(negedge DDRAM_CLK);
        src_addr = s; dst_addr = dd; num_bursts = n; start = 1'b1;
        dst_m = dd; hw_pushed = 0; gw = 0; toggles = 0; csum_m = 16'd0;
        done_cnt = 0; cpreq_cnt = 0;
        exp_addr_q.delete();
        for (int k = 0; k < int'(n); k++) exp_addr_q.push_back({s[27:10] + 18'(k), 10'd0});
        @(negedge DDRAM_CLK);
        start = 1'b0;
    endtask

    task automatic run_to_done(input int n, input int budget);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge DDRAM_CLK);
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            check_val("done_timeout", done, 1'b1);
        end else begin
            check_val("busy_at_done", busy, 1'b0);
            check_val("hw_count", toggles, n * 512);
            check_val("sb_left", exp_q.size(), 0);
            check_val("cpreq_count", cpreq_cnt, n);
            @(negedge DDRAM_CLK);
            check_val("done_one_cycle", done, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_cpreq", cpreq, 1'b0);
        check_val("rst_cpaddr", cpaddr, 28'd0);
        check_val("rst_sd_req", sd_req, 1'b0);
        check_val("rst_sd_addr", sd_addr, 25'd0);
        check_val("rst_sd_din", sd_din, 16'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ovf", ovf, 1'b0);
`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
        check_val("rst_csum", csum, 16'd0);
`endif
    endtask

    initial begin
        nRESET = 1'b0; start = 1'b0; src_addr = 28'd0; dst_addr = 25'd0; num_bursts = 16'd0;
        cpbusy = 1'b0; cpwr = 1'b0; cpdout = 64'd0; sd_ack = 1'b0;
        repeat (3) @(negedge DDRAM_CLK);
        check_reset_outputs();
        nRESET = 1'b1;
        repeat (2) @(negedge DDRAM_CLK);

        // Stray word while idle: dropped, ovf set and sticky.
        cpwr = 1'b1; cpdout = 64'hDEAD_BEEF_0000_0001;
        @(negedge DDRAM_CLK);
        cpwr = 1'b0;
        check_val("idle_ovf", ovf, 1'b1);
        check_val("idle_busy", busy, 1'b0);
        repeat (2) @(negedge DDRAM_CLK);
        check_val("ovf_sticky", ovf, 1'b1);

        // Single burst, word-index data, immediate ack.
        data_mode = 0; ack_delay = 0;
        start_copy(28'h001_0000, 25'd0, 16'd1);
        check_val("ovf_clear_on_start", ovf, 1'b0);
        check_val("busy_after_start", busy, 1'b1);
        run_to_done(1, 20000);

        // Source and destination wrap; a start during the copy must be ignored.
        data_mode = 2; ack_delay = 1;
        start_copy(28'hFFF_FC00, 25'h1FF_FF00, 16'd2);
        repeat (300) @(negedge DDRAM_CLK);
        src_addr = 28'd0; dst_addr = 25'h123; num_bursts = 16'd5; start = 1'b1;
        @(negedge DDRAM_CLK);
        start = 1'b0;
        run_to_done(2, 20000);

        // Three bursts with slow acks: FIFO backpressure, no overflow.
        data_mode = 2; ack_delay = 20;
        start_copy(28'hABC_D3FF, 25'h1FF_FFF0, 16'd3);
        run_to_done(3, 60000);
        check_val("ovf_slow_ack", ovf, 1'b0);

        // Zero-length copy.
        ack_delay = 0;
        start_copy(28'h000_0800, 25'd7, 16'd0);
        check_val("n0_done", done, 1'b1);
        check_val("n0_busy", busy, 1'b0);
        @(negedge DDRAM_CLK);
        check_val("n0_done_pulse", done, 1'b0);
        repeat (5) @(negedge DDRAM_CLK);
        check_val("n0_busy_later", busy, 1'b0);
        check_val("n0_no_cpreq", cpreq_cnt, 0);
        check_val("n0_no_write", toggles, 0);

        // Reset in the middle of the second burst, then a fresh copy.
        data_mode = 2; ack_delay = 0;
        start_copy(28'h200_0000, 25'h40, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge DDRAM_CLK);
            if (toggles >= 562) begin seen = 1'b1; break; end
        end
        check_val("midrst_reached", seen, 1'b1);
        check_val("midrst_busy", busy, 1'b1);
        done_save = done_cnt;
        nRESET = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge DDRAM_CLK);
        exp_q.delete();
        exp_addr_q.delete();
        nRESET = 1'b1;
        repeat (3) @(negedge DDRAM_CLK);
        check_val("midrst_no_done", done_cnt, done_save);
        check_val("midrst_idle", busy, 1'b0);
        data_mode = 0;
        start_copy(28'h000_0400, 25'h100, 16'd1);
        run_to_done(1, 20000);

`ifdef DDR_SDRAM_COPY_CHECKSUM_EN
        data_mode = 1; ack_delay = 0;
        start_copy(28'h000_0000, 25'd0, 16'd1);
        run_to_done(1, 20000);
        check_val("csum_const", csum, 16'h0200);
        check_val("csum_model", csum, csum_m);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
